// File: rtl/matmul_pkg.sv
// ============================================================================
// matmul_pkg : shared state encoding and sizing helpers for the MAC wave scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package matmul_pkg;

  localparam int DEFAULT_N = 3;

  typedef logic [2:0] state_t;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // A diagonal wavefront over an NxN array needs 3N-2 steps to sweep every PE.
  function automatic int steps_f(input int n);
    return 3 * n - 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sched_pe_decode.sv
// ============================================================================
// sched_pe_decode : per-PE enable / k-index decode for step t of the wavefront
// Rev 1.0
// ============================================================================
`default_nettype none

module sched_pe_decode #(
  parameter int N     = 3,
  parameter int I     = 0,
  parameter int J     = 0,
  parameter int TW    = 3,
  parameter int IDX_W = 2
) (
  input  logic [TW-1:0]    t_i,
  input  logic             run_i,
  output logic             en_o,
  output logic [IDX_W-1:0] k_o
);

  localparam int OFF = I + J;

  logic [TW:0] w_diff;
  logic        w_in_win;

  // PE(i,j) is active while t-i-j lies in [0, N-1]; the difference is then k.
  assign w_diff   = {1'b0, t_i} - (TW+1)'(OFF);
  assign w_in_win = ({1'b0, t_i} >= (TW+1)'(OFF)) && (w_diff <= (TW+1)'(N - 1));
  assign en_o     = run_i && w_in_win;
  assign k_o      = en_o ? IDX_W'(w_diff) : '0;

endmodule

`default_nettype wire

// File: rtl/matmul_wave_sched.sv
// ============================================================================
// matmul_wave_sched : clear/run/drain sequencer driving the NxN MAC array
// Rev 1.0
// ============================================================================
`default_nettype none

module matmul_wave_sched
  import matmul_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int IDX_W = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
  input  logic                              clk,
  input  logic                              Reset,
  input  logic                              start,
  input  logic                              abort,
  output logic                              busy,
  output logic                              done,
  output logic                              result_valid,
  output logic [N*N-1:0]                    mac_clr,
  output logic [N*N-1:0]                    mac_en,
  output logic [N*N*IDX_W-1:0]              mac_k,
  output logic [$clog2(steps_f(N))-1:0]     step
);

  localparam int STEPS  = steps_f(N);
  localparam int STEP_W = $clog2(STEPS);

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   t_q, t_d;
  logic                rv_q, rv_d;
  logic                w_run;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    rv_d    = rv_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          rv_d    = 1'b0;
        end
      end
      S_CLEAR: begin
        state_d = S_RUN;
        t_d     = '0;
      end
      S_RUN: begin
        if (t_q == STEP_W'(STEPS - 1)) begin
          state_d = S_DRAIN;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        rv_d    = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything above, including a start seen in IDLE.
    if (abort) begin
      state_d = S_IDLE;
      t_d     = '0;
      rv_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      rv_q    <= rv_d;
    end
  end

  assign w_run        = (state_q == S_RUN);
  assign busy         = (state_q == S_CLEAR) || w_run || (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);
  assign result_valid = rv_q;
  assign mac_clr      = {(N*N){state_q == S_CLEAR}};
  assign step         = t_q;

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      sched_pe_decode #(
        .N     (N),
        .I     (gi),
        .J     (gj),
        .TW    (STEP_W),
        .IDX_W (IDX_W)
      ) u_dec (
        .t_i   (t_q),
        .run_i (w_run),
        .en_o  (mac_en[gi*N+gj]),
        .k_o   (mac_k[(gi*N+gj)*IDX_W +: IDX_W])
      );
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_matmul_wave_sched.sv
// ============================================================================
// tb_matmul_wave_sched : vector table plus MAC-array scoreboard for the scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_matmul_wave_sched;
  import matmul_pkg::*;

  localparam int N     = 3;
  localparam int NN    = 9;
  localparam int IDX_W = 2;

  logic            clk   = 1'b0;
  logic            Reset = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            busy, done, result_valid;
  logic [NN-1:0]   mac_clr, mac_en;
  logic [NN*IDX_W-1:0] mac_k;
  logic [2:0]      step;

  matmul_wave_sched #(.N(N), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .result_valid (result_valid),
    .mac_clr      (mac_clr),
    .mac_en       (mac_en),
    .mac_k        (mac_k),
    .step         (step)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic        busy;
    logic        done;
    logic        rv;
    logic [8:0]  clr;
    logic [8:0]  en;
    logic [17:0] k;
    logic [2:0]  stp;
  } vec_t;

  vec_t tbl[11];

  // Behavioural MAC array fed by the scheduler outputs, and its reference results.
  logic [7:0]  A[3][3];
  logic [7:0]  B[3][3];
  logic [31:0] acc[NN];
  logic [31:0] exp_q[$];
  int          en_cnt[NN];

  initial for (int p = 0; p < NN; p++) begin
    acc[p]    = '0;
    en_cnt[p] = 0;
  end

  always @(posedge clk) begin
    for (int p = 0; p < NN; p++) begin
      int kk;
      kk = int'(mac_k[p*IDX_W +: IDX_W]);
      if (mac_clr[p])
        acc[p] <= '0;
      else if (mac_en[p])
        acc[p] <= (kk < N) ? acc[p] + A[p/N][kk] * B[kk][p%N] : 32'hDEAD_BEEF;
    end
  end

  always @(negedge clk) begin
    if (!Reset) begin
      for (int p = 0; p < NN; p++)
        if (mac_en[p]) en_cnt[p] = en_cnt[p] + 1;
      if (done) begin
        if (exp_q.size() < NN)
          chk("done_without_pending_run", {31'd0, done}, 32'd0);
        else
          for (int p = 0; p < NN; p++)
            chk($sformatf("C[%0d][%0d]", p / N, p % N), acc[p], exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_mats();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        A[i][j] = 8'($urandom_range(0, 15));
        B[i][j] = 8'($urandom_range(0, 15));
      end
  endtask

  task automatic push_expected();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < N; k++) s = s + A[i][k] * B[k][j];
        exp_q.push_back(s);
      end
  endtask

  task automatic chk_row(input vec_t v);
    chk($sformatf("c%0d_busy", v.cyc), {31'd0, busy}, {31'd0, v.busy});
    chk($sformatf("c%0d_done", v.cyc), {31'd0, done}, {31'd0, v.done});
    chk($sformatf("c%0d_rv",   v.cyc), {31'd0, result_valid}, {31'd0, v.rv});
    chk($sformatf("c%0d_clr",  v.cyc), {23'd0, mac_clr}, {23'd0, v.clr});
    chk($sformatf("c%0d_en",   v.cyc), {23'd0, mac_en},  {23'd0, v.en});
    chk($sformatf("c%0d_k",    v.cyc), {14'd0, mac_k},   {14'd0, v.k});
    chk($sformatf("c%0d_step", v.cyc), {29'd0, step},    {29'd0, v.stp});
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_rv"},   {31'd0, result_valid}, 32'd0);
    chk({tag, "_clr"},  {23'd0, mac_clr}, 32'd0);
    chk({tag, "_en"},   {23'd0, mac_en}, 32'd0);
    chk({tag, "_k"},    {14'd0, mac_k}, 32'd0);
    chk({tag, "_step"}, {29'd0, step}, 32'd0);
  endtask

  int base_cnt[NN];

  initial begin
    tbl[0]  = '{1,  1'b1, 1'b0, 1'b0, 9'h1FF, 9'h000, 18'h00000, 3'd0};
    tbl[1]  = '{2,  1'b1, 1'b0, 1'b0, 9'h000, 9'h001, 18'h00000, 3'd0};
    tbl[2]  = '{3,  1'b1, 1'b0, 1'b0, 9'h000, 9'h00B, 18'h00001, 3'd1};
    tbl[3]  = '{4,  1'b1, 1'b0, 1'b0, 9'h000, 9'h05F, 18'h00046, 3'd2};
    tbl[4]  = '{5,  1'b1, 1'b0, 1'b0, 9'h000, 9'h0FE, 18'h01198, 3'd3};
    tbl[5]  = '{6,  1'b1, 1'b0, 1'b0, 9'h000, 9'h1F4, 18'h06620, 3'd4};
    tbl[6]  = '{7,  1'b1, 1'b0, 1'b0, 9'h000, 9'h1A0, 18'h18800, 3'd5};
    tbl[7]  = '{8,  1'b1, 1'b0, 1'b0, 9'h000, 9'h100, 18'h20000, 3'd6};
    tbl[8]  = '{9,  1'b1, 1'b0, 1'b0, 9'h000, 9'h000, 18'h00000, 3'd0};
    tbl[9]  = '{10, 1'b0, 1'b1, 1'b1, 9'h000, 9'h000, 18'h00000, 3'd0};
    tbl[10] = '{11, 1'b0, 1'b0, 1'b1, 9'h000, 9'h000, 18'h00000, 3'd0};

    // Reset held for three edges, then released.
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("in_reset");
    Reset = 1'b0;
    tick();
    chk_quiet("after_reset");

    // Nominal run, walked cycle by cycle against the table.
    new_mats();
    push_expected();
    for (int p = 0; p < NN; p++) base_cnt[p] = en_cnt[p];
    start = 1'b1;
    for (int c = 0; c < 11; c++) begin
      tick();
      start = 1'b0;
      chk_row(tbl[c]);
    end
    for (int p = 0; p < NN; p++)
      chk($sformatf("pe%0d_en_count", p), en_cnt[p] - base_cnt[p], 32'd3);

    // Abort at t=3: idle next cycle, no done, result_valid cleared by the relaunch.
    new_mats();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("abort_pre_step", {29'd0, step}, 32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_quiet("abort_next");
    repeat (12) tick();
    chk("abort_rv_late", {31'd0, result_valid}, 32'd0);

    // abort and start together in IDLE.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk_quiet("abort_start_idle");

    // start during RUN (t=2) and during DONE is ignored.
    new_mats();
    push_expected();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("ign_step_t2", {29'd0, step}, 32'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("ign_done_c10", {31'd0, done}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_c11_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("ign_c12_busy", {31'd0, busy}, 32'd0);
    chk("ign_c12_clr", {23'd0, mac_clr}, 32'd0);

    // start held high relaunches after one idle cycle.
    new_mats();
    push_expected();
    push_expected();
    start = 1'b1;
    repeat (10) tick();
    chk("held_c10_done", {31'd0, done}, 32'd1);
    tick();
    chk("held_c11_busy", {31'd0, busy}, 32'd0);
    chk("held_c11_rv", {31'd0, result_valid}, 32'd1);
    tick();
    start = 1'b0;
    chk("held_c12_clr", {23'd0, mac_clr}, 32'h1FF);
    chk("held_c12_rv", {31'd0, result_valid}, 32'd0);
    repeat (10) tick();

    // Async Reset between edges in DRAIN.
    new_mats();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("drain_busy", {31'd0, busy}, 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    chk_quiet("async_rst_drain");
    tick();
    Reset = 1'b0;
    tick();
    chk_quiet("post_async_rst");

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
